// File: rtl/f2u_channel_arbiter.sv
// Round-robin arbiter sharing one pipelined float32->uint32 converter across
// NUM_CH requesters; results are steered back by a tag pipeline.
module f2u_channel_arbiter #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CONV_LATENCY = 6,
  parameter int unsigned DATA_W       = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     conv_in_valid,
  output logic [DATA_W-1:0]        conv_in_data,
  input  logic                     conv_out_valid,
  input  logic [DATA_W-1:0]        conv_out_data,
  output logic [NUM_CH-1:0]        res_valid,
  output logic [NUM_CH*DATA_W-1:0] res_data,
  input  logic [NUM_CH-1:0]        res_ready,
  output logic                     seq_err
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);
  localparam int unsigned NSTG  = CONV_LATENCY + 1;

  logic [NUM_CH-1:0]            busy;
  logic [NUM_CH-1:0]            eligible;
  logic [NUM_CH-1:0]            grant;
  logic [IDX_W-1:0]             rr_ptr;
  logic [IDX_W-1:0]             grant_idx;
  logic                         grant_any;
  logic [NSTG-1:0]              tag_vld;
  logic [NSTG-1:0][IDX_W-1:0]   tag_ch;
  logic [DATA_W-1:0]            req_word [NUM_CH];
  logic [DATA_W-1:0]            res_word [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign req_word[g]                   = req_data[g*DATA_W +: DATA_W];
    assign res_data[g*DATA_W +: DATA_W]  = res_word[g];
  end

  // busy reserves the result slot at issue, since the converter cannot stall
  assign eligible = req_valid & ~busy;

  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand     = (32'(rr_ptr) + k) % NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!grant_any && eligible[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Grant is combinational; masking with aresetn keeps req_ready low during reset
  assign req_ready = grant & {NUM_CH{aresetn}};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy          <= '0;
      rr_ptr        <= IDX_W'(NUM_CH - 1);
      conv_in_valid <= 1'b0;
      conv_in_data  <= '0;
      tag_vld       <= '0;
      tag_ch        <= '0;
      res_valid     <= '0;
      seq_err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) res_word[i] <= '0;
    end else begin
      conv_in_valid <= grant_any;
      tag_vld       <= {tag_vld[NSTG-2:0], grant_any};
      tag_ch        <= {tag_ch[NSTG-2:0], grant_idx};
      if (grant_any) begin
        conv_in_data     <= req_word[grant_idx];
        busy[grant_idx]  <= 1'b1;
        rr_ptr           <= grant_idx;
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          res_valid[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end
      end
      // Untagged converter output is dropped; a tag with no result leaves busy set
      if (tag_vld[NSTG-1] && conv_out_valid) begin
        res_valid[tag_ch[NSTG-1]] <= 1'b1;
        res_word[tag_ch[NSTG-1]]  <= conv_out_data;
      end
      if (tag_vld[NSTG-1] != conv_out_valid) seq_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_f2u_channel_arbiter.sv
// Bench for f2u_channel_arbiter with a truncating float->uint converter model
// and a per-handshake scoreboard of expected result data and arrival cycle.
module tb_f2u_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int LAT    = 6;
  localparam int DW     = 32;

  logic                    aclk = 1'b0;
  logic                    aresetn;
  logic [NUM_CH-1:0]       req_valid, req_ready, res_valid, res_ready;
  logic [NUM_CH*DW-1:0]    req_data, res_data;
  logic                    conv_in_valid, conv_out_valid, seq_err;
  logic [DW-1:0]           conv_in_data, conv_out_data;
  logic                    inj_valid;
  logic [DW-1:0]           inj_data;
  logic [LAT-1:0]          cv_pipe;
  logic [DW-1:0]           cd_pipe [LAT];
  logic [NUM_CH-1:0]       prev_rv;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int          ch;
    int          due;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  f2u_channel_arbiter #(.NUM_CH(NUM_CH), .CONV_LATENCY(LAT), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_in_valid(conv_in_valid), .conv_in_data(conv_in_data),
    .conv_out_valid(conv_out_valid), .conv_out_data(conv_out_data),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .seq_err(seq_err)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  function automatic logic [31:0] f2u(input logic [31:0] f);
    int          e;
    logic [63:0] m;
    e = int'({24'd0, f[30:23]}) - 127;
    if (f[31] || e < 0) return 32'd0;
    if (e > 31) return 32'hFFFF_FFFF;
    m = {40'd0, 1'b1, f[22:0]};
    if (e >= 23) m = m << (e - 23);
    else         m = m >> (23 - e);
    return m[31:0];
  endfunction

  // converter model: LAT-stage pipeline, reset together with the DUT
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cv_pipe <= '0;
      for (int i = 0; i < LAT; i++) cd_pipe[i] <= '0;
    end else begin
      cv_pipe    <= {cv_pipe[LAT-2:0], conv_in_valid};
      cd_pipe[0] <= f2u(conv_in_data);
      for (int i = 1; i < LAT; i++) cd_pipe[i] <= cd_pipe[i-1];
    end
  end
  assign conv_out_valid = cv_pipe[LAT-1] | inj_valid;
  assign conv_out_data  = inj_valid ? inj_data : cd_pipe[LAT-1];

  // scoreboard: push on handshake, pop on each new res_valid
  always @(negedge aclk) begin
    int idx;
    if (!aresetn) begin
      sb.delete();
      prev_rv = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (req_valid[i] && req_ready[i])
          sb.push_back('{i, cyc + LAT + 2, f2u(req_data[i*DW +: DW])});
      for (int i = 0; i < NUM_CH; i++) begin
        if (res_valid[i] && !prev_rv[i]) begin
          idx = -1;
          for (int j = 0; j < sb.size(); j++)
            if (idx < 0 && sb[j].ch == i) idx = j;
          n_vec++;
          if (idx < 0) begin
            n_err++;
            $display("FAIL sb_unexpected ch%0d got %h required no result", i, res_data[i*DW +: DW]);
          end else begin
            if (res_data[i*DW +: DW] !== sb[idx].d || cyc != sb[idx].due) begin
              n_err++;
              $display("FAIL sb_result ch%0d got %h@%0d required %h@%0d",
                       i, res_data[i*DW +: DW], cyc, sb[idx].d, sb[idx].due);
            end
            sb.delete(idx);
          end
        end
      end
      prev_rv = res_valid;
    end
  end

  task automatic apply_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn   = 1'b0;
    inj_valid = 1'b0;
    inj_data  = '0;
    req_valid = '1;
    req_data  = {4{32'h3F80_0000}};
    res_ready = '0;
    repeat (2) @(negedge aclk);
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready got %b required 0000", req_ready); end
    n_vec++; if (conv_in_valid !== 1'b0) begin n_err++; $display("FAIL rst_conv_in_valid got %b required 0", conv_in_valid); end
    n_vec++; if (conv_in_data !== 32'd0) begin n_err++; $display("FAIL rst_conv_in_data got %h required 0", conv_in_data); end
    n_vec++; if (res_valid !== 4'b0000) begin n_err++; $display("FAIL rst_res_valid got %b required 0000", res_valid); end
    n_vec++; if (res_data !== '0) begin n_err++; $display("FAIL rst_res_data got %h required 0", res_data); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL rst_seq_err got %b required 0", seq_err); end
    @(posedge aclk); #1;
    req_valid = '0;
    aresetn   = 1'b1;
  endtask

  task automatic test_single();
    int t_hs;
    @(posedge aclk); #1;
    req_data[31:0] = 32'h4627_C5AC;
    req_valid      = 4'b0001;
    @(negedge aclk);
    t_hs = cyc;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b required 0001", req_ready); end
    @(posedge aclk); #1;
    req_valid = '0;
    @(negedge aclk);
    n_vec++; if (conv_in_valid !== 1'b1 || conv_in_data !== 32'h4627_C5AC) begin
      n_err++; $display("FAIL single_conv_in got %b/%h required 1/4627c5ac", conv_in_valid, conv_in_data);
    end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_grant_once got %b required 0000", req_ready); end
    for (int k = 0; k < 20 && !res_valid[0]; k++) @(negedge aclk);
    n_vec++; if (res_valid[0] !== 1'b1 || cyc != t_hs + 8) begin
      n_err++; $display("FAIL single_latency got valid=%b at +%0d required valid=1 at +8", res_valid[0], cyc - t_hs);
    end
    n_vec++; if (res_data[31:0] !== 32'h0000_29F1) begin n_err++; $display("FAIL single_data got %h required 000029f1", res_data[31:0]); end
    @(posedge aclk); #1;
    res_ready = 4'b0001;
    @(negedge aclk);
    @(negedge aclk);
    n_vec++; if (res_valid[0] !== 1'b0) begin n_err++; $display("FAIL single_consume got %b required 0", res_valid[0]); end
    res_ready = '0;
  endtask

  task automatic test_round_robin();
    int t0, t1;
    apply_reset();
    @(posedge aclk); #1;
    req_data  = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    res_ready = '1;
    req_valid = '1;
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      if (k == 0) t0 = cyc;
      n_vec++; if (req_ready !== (4'b0001 << k)) begin
        n_err++; $display("FAIL rr_order step%0d got %b required %b", k, req_ready, 4'b0001 << k);
      end
    end
    t1 = -1;
    for (int k = 0; k < 20 && t1 < 0; k++) begin
      @(negedge aclk);
      if (req_ready[0]) t1 = cyc;
    end
    n_vec++; if (t1 - t0 != 9) begin n_err++; $display("FAIL rr_regrant got %0d cycles required 9", t1 - t0); end
    @(posedge aclk); #1;
    req_valid = '0;
    repeat (14) @(negedge aclk);
  endtask

  task automatic test_tagging();
    logic [NUM_CH-1:0] g1, g2;
    @(posedge aclk); #1;
    req_data[63:32] = 32'h3F80_0000;
    req_data[95:64] = 32'h4040_0000;
    res_ready       = '0;
    req_valid       = 4'b0110;
    @(negedge aclk);
    g1 = req_ready;
    @(posedge aclk); #1;
    req_valid = req_valid & ~g1;
    @(negedge aclk);
    g2 = req_ready;
    @(posedge aclk); #1;
    req_valid = '0;
    n_vec++; if ((g1 | g2) !== 4'b0110 || (g1 & g2) !== 4'b0000) begin
      n_err++; $display("FAIL tag_grants got %b,%b required 0110 split", g1, g2);
    end
    for (int k = 0; k < 20 && res_valid[2:1] != 2'b11; k++) @(negedge aclk);
    n_vec++; if (res_valid !== 4'b0110) begin n_err++; $display("FAIL tag_valid got %b required 0110", res_valid); end
    n_vec++; if (res_data[63:32] !== 32'd1) begin n_err++; $display("FAIL tag_ch1 got %h required 1", res_data[63:32]); end
    n_vec++; if (res_data[95:64] !== 32'd3) begin n_err++; $display("FAIL tag_ch2 got %h required 3", res_data[95:64]); end
    @(posedge aclk); #1;
    res_ready = '1;
    repeat (2) @(negedge aclk);
  endtask

  task automatic test_backpressure();
    int n3, n_other, viol;
    n3 = 0; n_other = 0; viol = 0;
    @(posedge aclk); #1;
    req_data  = {32'h4120_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    res_ready = 4'b0111;
    req_valid = '1;
    repeat (30) begin
      @(negedge aclk);
      if (req_valid[3] && req_ready[3]) n3++;
      if (req_ready[2:0] != 3'b000) n_other++;
      if (res_valid[3] && req_ready[3]) viol++;
    end
    n_vec++; if (n3 != 1) begin n_err++; $display("FAIL bp_ch3_issues got %0d required 1", n3); end
    n_vec++; if (viol != 0) begin n_err++; $display("FAIL bp_ready_while_held got %0d required 0", viol); end
    n_vec++; if (n_other < 6) begin n_err++; $display("FAIL bp_others_served got %0d required >=6", n_other); end
    @(posedge aclk); #1;
    req_valid = 4'b1000;
    repeat (12) @(negedge aclk);
    n_vec++; if (res_valid !== 4'b1000) begin n_err++; $display("FAIL bp_held got %b required 1000", res_valid); end
    @(posedge aclk); #1;
    res_ready = '1;
    @(negedge aclk);
    n_vec++; if (req_ready[3] !== 1'b0) begin n_err++; $display("FAIL bp_consume_cycle got %b required 0", req_ready[3]); end
    @(negedge aclk);
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_regrant got %b required 1000", req_ready); end
    @(posedge aclk); #1;
    req_valid = '0;
    repeat (12) @(negedge aclk);
  endtask

  task automatic test_mismatch();
    logic [NUM_CH-1:0] rv_before;
    @(negedge aclk);
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL mm_pre got %b required 0", seq_err); end
    rv_before = res_valid;
    @(posedge aclk); #1;
    inj_valid = 1'b1;
    inj_data  = 32'hDEAD_BEEF;
    @(posedge aclk); #1;
    inj_valid = 1'b0;
    @(negedge aclk);
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL mm_flag got %b required 1", seq_err); end
    n_vec++; if (res_valid !== rv_before) begin n_err++; $display("FAIL mm_res_valid got %b required %b", res_valid, rv_before); end
    repeat (5) @(negedge aclk);
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL mm_sticky got %b required 1", seq_err); end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL mm_reset got %b required 0", seq_err); end
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(posedge aclk); #1;
    req_data[31:0] = 32'h4627_C5AC;
    req_valid      = 4'b0001;
    res_ready      = '1;
    @(negedge aclk);
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mf_grant got %b required 0001", req_ready); end
    @(posedge aclk); #1;
    req_valid = '0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    n_vec++; if ({req_ready, conv_in_valid, res_valid, seq_err} !== '0 || conv_in_data !== '0 || res_data !== '0) begin
      n_err++; $display("FAIL mf_clear got rr=%b civ=%b cid=%h rv=%b se=%b required all 0",
                        req_ready, conv_in_valid, conv_in_data, res_valid, seq_err);
    end
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge aclk);
      if (res_valid[0] || seq_err) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL mf_no_result got %0d cycles required 0", seen); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_tagging();
    test_backpressure();
    test_mismatch();
    test_reset_midflight();
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_drain got %0d pending required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
